// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the cascadable BCD counter chain.
package bcd_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned LE_W       = BCD_W * MAX_DIGITS;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic bcd_valid(input bcd_digit_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

  // a <= b over the low 'digits' nibbles, most significant digit decides first
  function automatic logic bcd_le(input logic [LE_W-1:0] a,
                                  input logic [LE_W-1:0] b,
                                  input int unsigned     digits);
    logic decided;
    logic le;
    decided = 1'b0;
    le      = 1'b1;
    for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
      if (!decided && (i < int'(digits))) begin
        if (a[i*BCD_W +: BCD_W] < b[i*BCD_W +: BCD_W]) begin
          decided = 1'b1;
          le      = 1'b1;
        end else if (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]) begin
          decided = 1'b1;
          le      = 1'b0;
        end
      end
    end
    return le;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit's next-value logic: wrap override, increment/decrement with 9<->0 roll.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t cur,
  input  logic       inc,
  input  logic       dec,
  input  logic       wrap,
  input  bcd_digit_t rollover,
  output bcd_digit_t digit_nxt_c,
  output logic       at_max_c,
  output logic       at_zero_c
);

  assign at_max_c  = (cur == BCD_MAX);
  assign at_zero_c = (cur == '0);

  always_comb begin
    digit_nxt_c = cur;
    if (wrap) begin
      digit_nxt_c = rollover;
    end else if (inc) begin
      digit_nxt_c = at_max_c ? '0 : cur + 4'd1;
    end else if (dec) begin
      digit_nxt_c = at_zero_c ? BCD_MAX : cur - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter wrapping at TOP, with load check and cascade pulses.
// Define COUNT_SAT_EN to make counting saturate at TOP / 0 instead of wrapping.
module bcd_counter_chain
  import bcd_pkg::*;
#(
  parameter int unsigned              DIGITS = 2,
  parameter logic [BCD_W*DIGITS-1:0]  TOP    = 8'h59
) (
  input  logic                    fclk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] nout,
  output logic                    cy,
  output logic                    bw,
  output logic                    load_err
);

  localparam int unsigned CNT_W = BCD_W * DIGITS;

  logic [CNT_W-1:0]  nout_q, nout_d;
  logic              cy_q, cy_d;
  logic              bw_q, bw_d;
  logic              load_err_q, load_err_d;

  logic [CNT_W-1:0]  nout_step;
  logic [CNT_W-1:0]  wrap_val;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] inc_en;
  logic [DIGITS-1:0] dec_en;
  logic [DIGITS-1:0] nib_ok;
  logic              at_top, at_bottom, load_ok;
  logic              inc_go, dec_go, wrap_go;
  logic              msd_at_max_unused;

  assign at_top            = (nout_q == TOP);
  assign at_bottom         = &at_zero;
  assign msd_at_max_unused = at_max[DIGITS-1];
  assign wrap_val          = up ? '0 : TOP;
  assign load_ok           = (&nib_ok) && bcd_le(LE_W'(load_val), LE_W'(TOP), DIGITS);

  // A step is only taken when not loading and not sitting at the limit in that direction
  assign inc_go = !load && en &&  up && !at_top;
  assign dec_go = !load && en && !up && !at_bottom;
`ifdef COUNT_SAT_EN
  assign wrap_go = 1'b0;
`else
  assign wrap_go = !load && en && (up ? at_top : at_bottom);
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign inc_en[g] = inc_go;
      assign dec_en[g] = dec_go;
    end else begin : g_upper
      assign inc_en[g] = inc_go && (&at_max[g-1:0]);
      assign dec_en[g] = dec_go && (&at_zero[g-1:0]);
    end

    assign nib_ok[g] = bcd_valid(load_val[g*BCD_W +: BCD_W]);

    bcd_digit u_digit (
      .cur         (nout_q[g*BCD_W +: BCD_W]),
      .inc         (inc_en[g]),
      .dec         (dec_en[g]),
      .wrap        (wrap_go),
      .rollover    (wrap_val[g*BCD_W +: BCD_W]),
      .digit_nxt_c (nout_step[g*BCD_W +: BCD_W]),
      .at_max_c    (at_max[g]),
      .at_zero_c   (at_zero[g])
    );
  end

  // Next count, sticky load error and cascade pulses
  always_comb begin
    nout_d     = nout_step;
    load_err_d = load_err_q;
    cy_d       = 1'b0;
    bw_d       = 1'b0;
    if (load) begin
      nout_d = load_ok ? load_val : nout_q;
      if (!load_ok) begin
        load_err_d = 1'b1;
      end
    end else begin
`ifdef COUNT_SAT_EN
      cy_d = inc_go && (nout_step == TOP);
      bw_d = dec_go && (nout_step == '0);
`else
      cy_d = wrap_go &&  up;
      bw_d = wrap_go && !up;
`endif
    end
  end

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      nout_q     <= '0;
      cy_q       <= 1'b0;
      bw_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      nout_q     <= nout_d;
      cy_q       <= cy_d;
      bw_q       <= bw_d;
      load_err_q <= load_err_d;
    end
  end

  assign nout     = nout_q;
  assign cy       = cy_q;
  assign bw       = bw_q;
  assign load_err = load_err_q;

endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
Parametrised multi-digit BCD counter with programmable terminal value, up/down counting, synchronous load and registered carry/borrow pulses for cascading. It generalises the single-digit decade counter into the timebase/display path, e.g. seconds/minutes (TOP=59) or hours (TOP=23). It is driven by the divided clock and feeds seven-segment decoders and the next cascade stage.

Parameters:
DIGITS, 2, number of BCD digits (1..8)
TOP, 8'h59, packed-BCD terminal value, width 4*DIGITS; every nibble must be ≤9; the wrap point is TOP

Ports:
fclk  in  1  divided count clock, rising edge active
reset  in  1  asynchronous active-low reset
en  in  1  count enable, active-high, sampled on fclk
up  in  1  direction: 1 = increment, 0 = decrement
load  in  1  synchronous load strobe, active-high
load_val  in  4*DIGITS  packed-BCD value to load
nout  out  4*DIGITS  packed-BCD count, digit 0 in bits [3:0]
cy  out  1  one-cycle pulse on the up-wrap TOP→0
bw  out  1  one-cycle pulse on the down-wrap 0→TOP
load_err  out  1  sticky flag: an invalid load was rejected

Behaviour:
- Reset (reset=0, asynchronous): nout=0, cy=0, bw=0, load_err=0. Reset has priority over everything. If reset is asserted mid-count, the count is discarded and no pulse is emitted.
- Priority per fclk edge: load > en > hold.
- Load: if every nibble of load_val is ≤9 and load_val ≤ TOP (BCD compare, MS digit first), then nout←load_val. Otherwise nout is unchanged and load_err←1. cy=bw=0 on any load cycle.
- load_err clears only on reset.
- en=1, up=1: if nout==TOP, then nout←0 and cy=1. Otherwise nout is incremented in BCD: digit i increments when all lower digits are 9; a digit at 9 rolls to 0.
- en=1, up=0: if nout==0, then nout←TOP and bw=1. Otherwise nout is decremented in BCD: a digit at 0 rolls to 9 and borrows from the next digit.
- en=0, no load: nout holds; cy=bw=0.
- cy and bw are registered and asserted for exactly the cycle following the wrap edge. They are never both 1.
- Latency: nout updates on the same edge at which en or load is sampled.
- Direction change takes effect immediately on the next enabled edge; no state is carried across the change.
- Single combined TOP compare; no out-of-range state is reachable (the load check guarantees this).

Optional Feature:
COUNT_SAT_EN. When defined, counting saturates instead of wrapping:
- up at TOP → nout holds TOP and cy pulses once, on the edge that reaches TOP.
- down at 0 → nout holds 0 and bw pulses once, on the edge that reaches 0.
- Further enabled edges at the limit produce no pulse.
When undefined, counting wraps as described in Behaviour.

Decomposition:
Shared package bcd_pkg:
- BCD_W=4
- BCD_MAX=4'd9
- typedef bcd_digit_t (logic [3:0])
- function bcd_valid(nibble)
- function bcd_le(a,b,digits)

Sub-module bcd_digit, instantiated DIGITS times via generate:
- inputs: inc, dec, rollover value
- outputs: digit, at_max (==9), at_zero (==0)
- carry/borrow enables are chained combinationally from lower digits.
- TOP wrap detection and load validation stay in the top module.

Test Plan:
1. Reset: DIGITS=2, TOP=8'h59. Assert reset for 3 cycles with en=1 → nout=8'h00, cy=bw=load_err=0; first enabled edge after release gives nout=8'h01.
2. Up wrap: load 8'h58, en=1, up=1 → 8'h59, then 8'h00 with cy=1 for exactly one cycle; intermediate 8'h09→8'h10 carry checked.
3. Down wrap: load 8'h01, up=0 → 8'h00, then 8'h59 with bw=1 for one cycle; 8'h10→8'h09 borrow checked.
4. Invalid load: load_val=8'h3A → nout unchanged, load_err=1. load_val=8'h60 → rejected. load_val=8'h45 → accepted, load_err stays 1 until reset.
5. Simultaneous: load=1, en=1 at nout=TOP with load_val=8'h12 → nout=8'h12, cy=0. en=0 → holds for 5 cycles.
6. COUNT_SAT_EN build: count up from 8'h57 for 5 edges → 8'h59 held, single cy pulse; then down from 8'h01 for 3 edges → held at 8'h00, single bw pulse.
